// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish one cycle after start; MUL is shift-add over WIDTH cycles.
// ready=1 only when idle; start is ignored while busy; done pulses for one cycle when result/flags update.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam logic [7:0] OP_AND = 8'b0000_0001;
  localparam logic [7:0] OP_OR  = 8'b0000_0010;
  localparam logic [7:0] OP_XOR = 8'b0000_0011;
  localparam logic [7:0] OP_ADD = 8'b0000_0101;
  localparam logic [7:0] OP_SUB = 8'b0000_1001;
  localparam logic [7:0] OP_CMP = 8'b0000_1011;
  localparam logic [7:0] OP_MOV = 8'b0000_1101;
  localparam logic [7:0] OP_MUL = 8'b0000_1110;
  localparam logic [7:0] OP_LSH = 8'b1000_0100;

  localparam int FC = 0;
  localparam int FL = 1;
  localparam int FF = 2;
  localparam int FZ = 3;
  localparam int FN = 4;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [7:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   neg_b;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    neg_b    = -b_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d  = a;
          b_d  = b;
          op_d = op;
          if (op == OP_MUL) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            state_d  = MUL;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        done_d  = 1'b1;
        state_d = IDLE;
        unique case (op_q)
          OP_AND: result_d = a_q & b_q;
          OP_OR:  result_d = a_q | b_q;
          OP_XOR: result_d = a_q ^ b_q;
          OP_MOV: result_d = b_q;
          OP_ADD: begin
            result_d    = sum[WIDTH-1:0];
            flags_d[FC] = sum[WIDTH];
            flags_d[FF] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_SUB: begin
            result_d    = diff[WIDTH-1:0];
            flags_d[FC] = diff[WIDTH];
            flags_d[FF] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_CMP: begin
            flags_d[FZ] = (a_q == b_q);
            flags_d[FL] = (a_q < b_q);
            flags_d[FN] = ($signed(a_q) < $signed(b_q));
          end
          OP_LSH: begin
            // Negative b selects a logical right shift by its magnitude.
            if (b_q[WIDTH-1]) result_d = a_q >> neg_b[SHW-1:0];
            else              result_d = a_q << b_q[SHW-1:0];
          end
          default: result_d = '0;
        endcase
      end

      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d    = acc_next[WIDTH-1:0];
          flags_d[FF] = |acc_next[2*WIDTH-1:WIDTH];
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule
